// File: rtl/partial_product_generator_if.sv
// Operand request / partial-product stream bundle between the multiplier
// front end and its requester and accumulator.
interface partial_product_generator_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  start;
    logic [DATA_WIDTH-1:0] multiplicand;
    logic [DATA_WIDTH-1:0] multiplier;
    logic [DATA_WIDTH-1:0] partial_product;
    logic                  partial_product_valid;
    logic                  busy;
    logic                  done;
    logic                  pp_overflow;

    // Requester side: issues operands, observes the stream.
    modport master (
        output start, multiplicand, multiplier,
        input  partial_product, partial_product_valid, busy, done, pp_overflow
    );

    // Generator side.
    modport slave (
        input  start, multiplicand, multiplier,
        output partial_product, partial_product_valid, busy, done, pp_overflow
    );
endinterface

// File: rtl/partial_product_generator.sv
// Shift-add multiplier front end: streams one partial product per cycle,
// multiplier LSB first, then a one-cycle done gap for the accumulator.
module partial_product_generator #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter bit          SIGNED_MODE = 1'b1
) (
    input logic                     clk,
    input logic                     reset_n,
    partial_product_generator_if.slave bus
);
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [DATA_WIDTH-1:0] mcand, mcand_nxt;
    logic [DATA_WIDTH-1:0] mplier, mplier_nxt;
    logic [DATA_WIDTH-1:0] pp, pp_nxt;
    logic                  valid, valid_nxt;
    logic                  busy, busy_nxt;
    logic                  done, done_nxt;
    logic                  ovf, ovf_nxt;

    logic                  accept_c;
    logic [DATA_WIDTH-1:0] sel_mcand_c;
    logic [DATA_WIDTH-1:0] sel_mplier_c;
    logic [IDX_W-1:0]      sel_idx_c;
    logic [DATA_WIDTH-1:0] pp_c;
    logic                  ovf_c;

    // Operands/index feeding the next presented partial product: the incoming
    // pair on an accepted start, otherwise the latched pair at idx+1.
    always_comb begin : source_select
        accept_c     = (state != EMIT) && bus.start;
        sel_mcand_c  = mcand;
        sel_mplier_c = mplier;
        sel_idx_c    = idx + IDX_W'(1);
        if (accept_c) begin
            sel_mcand_c  = bus.multiplicand;
            sel_mplier_c = bus.multiplier;
            sel_idx_c    = '0;
        end
    end

    // Partial product for the selected index; the signed MSB row is negated,
    // and negating the most negative value wraps onto itself.
    always_comb begin : pp_compute
        pp_c  = '0;
        ovf_c = 1'b0;
        if (sel_mplier_c[sel_idx_c]) begin
            if (SIGNED_MODE && (sel_idx_c == LAST_IDX)) begin
                pp_c  = '0 - sel_mcand_c;
                ovf_c = (sel_mcand_c == MIN_NEG);
            end else begin
                pp_c = sel_mcand_c;
            end
        end
    end

    // Next state and next registered outputs.
    always_comb begin : fsm_next
        state_nxt  = state;
        idx_nxt    = idx;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        pp_nxt     = '0;
        valid_nxt  = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        ovf_nxt    = 1'b0;

        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (accept_c) begin
                    state_nxt  = EMIT;
                    idx_nxt    = '0;
                    mcand_nxt  = bus.multiplicand;
                    mplier_nxt = bus.multiplier;
                    pp_nxt     = pp_c;
                    ovf_nxt    = ovf_c;
                    valid_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
                end
            end
            EMIT: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                    idx_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt   = idx + IDX_W'(1);
                    pp_nxt    = pp_c;
                    ovf_nxt   = ovf_c;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge reset_n) begin : fsm_regs
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= '0;
            mcand  <= '0;
            mplier <= '0;
            pp     <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            pp     <= pp_nxt;
            valid  <= valid_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            ovf    <= ovf_nxt;
        end
    end

    assign bus.partial_product       = pp;
    assign bus.partial_product_valid = valid;
    assign bus.busy                  = busy;
    assign bus.done                  = done;
    assign bus.pp_overflow           = ovf;

endmodule

// File: tb/tb_partial_product_generator.sv
// Bench for partial_product_generator: unsigned and signed instances share
// one stimulus stream and are compared against an arithmetic reference.
module tb_partial_product_generator;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] mc_in;
    logic [W-1:0] mp_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    partial_product_generator_if #(.DATA_WIDTH(W)) ifu ();
    partial_product_generator_if #(.DATA_WIDTH(W)) ifs ();

    assign ifu.start        = start;
    assign ifu.multiplicand = mc_in;
    assign ifu.multiplier   = mp_in;
    assign ifs.start        = start;
    assign ifs.multiplicand = mc_in;
    assign ifs.multiplier   = mp_in;

    partial_product_generator #(.DATA_WIDTH(W), .SIGNED_MODE(1'b0)) dut_u (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifu)
    );

    partial_product_generator #(.DATA_WIDTH(W), .SIGNED_MODE(1'b1)) dut_s (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifs)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: row i is mcand when multiplier bit i is set; the signed MSB
    // row is the negated multiplicand modulo 2^W. Returns {overflow, pp}.
    function automatic logic [W:0] model_pp(input logic [W-1:0] mc, input logic [W-1:0] mp,
                                            input int i, input bit sm);
        int v;
        bit o;
        v = 0;
        o = 1'b0;
        if (mp[i]) begin
            if (sm && i == W - 1) begin
                v = (65536 - int'(mc)) % 65536;
                o = (int'(mc) == 32768);
            end else begin
                v = int'(mc);
            end
        end
        return {o, 16'(v)};
    endfunction

    task automatic check_idle(input string tag, input logic exp_done);
        check_eq({tag, "/u_valid"}, 32'(ifu.partial_product_valid), 32'd0);
        check_eq({tag, "/u_pp"},    32'(ifu.partial_product),       32'd0);
        check_eq({tag, "/u_busy"},  32'(ifu.busy),                  32'd0);
        check_eq({tag, "/u_ovf"},   32'(ifu.pp_overflow),           32'd0);
        check_eq({tag, "/u_done"},  32'(ifu.done),                  32'(exp_done));
        check_eq({tag, "/s_valid"}, 32'(ifs.partial_product_valid), 32'd0);
        check_eq({tag, "/s_pp"},    32'(ifs.partial_product),       32'd0);
        check_eq({tag, "/s_busy"},  32'(ifs.busy),                  32'd0);
        check_eq({tag, "/s_ovf"},   32'(ifs.pp_overflow),           32'd0);
        check_eq({tag, "/s_done"},  32'(ifs.done),                  32'(exp_done));
    endtask

    task automatic check_row(input string tag, input logic [W-1:0] mc, input logic [W-1:0] mp,
                             input int i);
        logic [W:0] eu;
        logic [W:0] es;
        eu = model_pp(mc, mp, i, 1'b0);
        es = model_pp(mc, mp, i, 1'b1);
        check_eq($sformatf("%s/u_pp%0d", tag, i),  32'(ifu.partial_product), 32'(eu[W-1:0]));
        check_eq($sformatf("%s/u_ovf%0d", tag, i), 32'(ifu.pp_overflow),     32'(eu[W]));
        check_eq($sformatf("%s/s_pp%0d", tag, i),  32'(ifs.partial_product), 32'(es[W-1:0]));
        check_eq($sformatf("%s/s_ovf%0d", tag, i), 32'(ifs.pp_overflow),     32'(es[W]));
        check_eq($sformatf("%s/valid%0d", tag, i),
                 32'({ifu.partial_product_valid, ifs.partial_product_valid}), 32'h3);
        check_eq($sformatf("%s/busy%0d", tag, i),  32'({ifu.busy, ifs.busy}), 32'h3);
        check_eq($sformatf("%s/done%0d", tag, i),  32'({ifu.done, ifs.done}), 32'h0);
    endtask

    // Called at a negedge with the DUTs idle or in their done cycle; returns
    // at the negedge of the done cycle. ignore_at >= 0 raises start mid-stream.
    task automatic do_op(input logic [W-1:0] mc, input logic [W-1:0] mp,
                         input int ignore_at, input string tag);
        start = 1'b1;
        mc_in = mc;
        mp_in = mp;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            mc_in = W'($urandom);
            mp_in = W'($urandom);
            check_row(tag, mc, mp, i);
            start = (i == ignore_at);
            @(negedge clk);
        end
        start = 1'b0;
        check_idle({tag, "/done_cycle"}, 1'b1);
    endtask

    task automatic idle_cycle(input string tag);
        start = 1'b0;
        @(negedge clk);
        check_idle(tag, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        mc_in   = '0;
        mp_in   = '0;

        // Reset with random inputs.
        for (int c = 0; c < 3; c++) begin
            start = 1'($urandom);
            mc_in = W'($urandom);
            mp_in = W'($urandom);
            @(negedge clk);
            check_idle("reset", 1'b0);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) idle_cycle("post_reset");

        do_op(16'h0005, 16'h0003, -1, "unsigned");
        idle_cycle("after_unsigned");
        do_op(16'h0007, 16'h8001, -1, "signed_msb");
        idle_cycle("after_signed");
        do_op(16'h8000, 16'h8000, -1, "overflow");
        idle_cycle("after_overflow");
        do_op(16'h1234, 16'hA5C3, 5, "start_busy");
        idle_cycle("after_start_busy");

        // Reset mid-operation at emit cycle 8.
        start = 1'b1;
        mc_in = 16'h00FF;
        mp_in = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_row("pre_abort", 16'h00FF, 16'hFFFF, i);
            @(negedge clk);
        end
        check_row("pre_abort", 16'h00FF, 16'hFFFF, 8);
        reset_n = 1'b0;
        #1;
        check_idle("abort_async", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) idle_cycle("after_abort");

        // Back-to-back: start raised during the done cycle.
        do_op(16'hBEEF, 16'h8421, -1, "b2b_a");
        do_op(16'h8000, 16'hFFFF, -1, "b2b_b");
        idle_cycle("after_b2b");

        // Randomized operations with random gaps and ignored starts.
        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] mc;
            logic [W-1:0] mp;
            int ig;
            mc = ($urandom_range(0, 3) == 0) ? 16'h8000 : W'($urandom);
            mp = W'($urandom);
            if ($urandom_range(0, 1) == 1) mp[W-1] = 1'b1;
            ig = int'($urandom_range(0, 20));
            if (ig > 14) ig = -1;
            do_op(mc, mp, ig, $sformatf("rand%0d", n));
            if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rand_gap%0d", n));
        end
        idle_cycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
